pcileech_pcie_link_supervisor: RTL and testbench

// Reset/link supervisor for the PCIe hard core, generalised to LANES = 1/2/4/8.

---
 rtl/pcileech_pcie_link_supervisor_if.sv | 28 ++
 rtl/pcileech_pcie_link_supervisor.sv | 171 +++++++++++++++++
 tb/tb_pcileech_pcie_link_supervisor.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pcileech_pcie_link_supervisor_if.sv
// Control/status bundle between the link supervisor and the pcie_7x hard core.
interface pcileech_pcie_link_supervisor_if;
  logic       user_lnk_up;
  logic [1:0] pl_sel_lnk_width;
  logic [5:0] pl_ltssm_state;
  logic       pl_received_hot_rst;
  logic       pl_directed_change_done;
  logic       core_rst;
  logic       subsys_rst;
  logic [1:0] pl_directed_link_change;
  logic [1:0] pl_directed_link_width;
  logic       pl_directed_link_auton;

  // Supervisor side: drives resets and directed-change requests into the core.
  modport master (
    input  user_lnk_up, pl_sel_lnk_width, pl_ltssm_state,
           pl_received_hot_rst, pl_directed_change_done,
    output core_rst, subsys_rst, pl_directed_link_change,
           pl_directed_link_width, pl_directed_link_auton
  );

  modport slave (
    output user_lnk_up, pl_sel_lnk_width, pl_ltssm_state,
           pl_received_hot_rst, pl_directed_change_done,
    input  core_rst, subsys_rst, pl_directed_link_change,
           pl_directed_link_width, pl_directed_link_auton
  );
endinterface

// File: rtl/pcileech_pcie_link_supervisor.sv
// PCIe reset/link supervisor on free-running clk_100: PERST# debounce, reset sequencing,
// link-up timeout with bounded retry, one directed width retrain per link-up, state LED.
module pcileech_pcie_link_supervisor #(
  parameter int unsigned LANES          = 1,
  parameter int unsigned DEBOUNCE_CYC   = 1000,
  parameter int unsigned HOLD_CYC       = 100,
  parameter int unsigned TRAIN_TO_CYC   = 2**24,
  parameter int unsigned RETRAIN_TO_CYC = 2**20,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter int unsigned RETRAIN_EN     = 1,
  parameter int unsigned LED_BIT        = 25
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            pcie_perst_n,
  input  logic                            sw_rst_core,
  pcileech_pcie_link_supervisor_if.master pcie,
  output logic [2:0]                      link_state,
  output logic [3:0]                      retry_count,
  output logic [7:0]                      downtrain_count,
  output logic                            width_err,
  output logic                            led_state
);

  localparam int unsigned MAX_AB  = (DEBOUNCE_CYC > HOLD_CYC) ? DEBOUNCE_CYC : HOLD_CYC;
  localparam int unsigned MAX_CD  = (TRAIN_TO_CYC > RETRAIN_TO_CYC) ? TRAIN_TO_CYC : RETRAIN_TO_CYC;
  localparam int unsigned TMR_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
  localparam int unsigned TICK_W  = LED_BIT + 1;
  localparam logic [1:0]  EXP_W   = 2'($clog2(LANES));
  localparam logic [5:0]  LTSSM_L0 = 6'h16;

  typedef enum logic [2:0] {
    ST_RESET   = 3'd0,
    ST_HOLD    = 3'd1,
    ST_TRAIN   = 3'd2,
    ST_UP      = 3'd3,
    ST_RETRAIN = 3'd4,
    ST_FAIL    = 3'd5
  } state_e;

  logic [1:0]        perst_ff, lnk_ff;
  logic [1:0]        width_ff, width_s;
  logic              perst_s, lnk_s;
  state_e            state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [3:0]        retry_q, retry_d;
  logic [7:0]        dtc_q, dtc_d;
  logic              werr_q, werr_d;
  logic              used_q, used_d;
  logic              chk_q, chk_d;
  logic [TICK_W-1:0] tick_q, tick_d;

  assign perst_s = perst_ff[1];
  assign lnk_s   = lnk_ff[1];

  // Two-flop synchronisers for board and core-clock-domain inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perst_ff <= 2'b00;
      lnk_ff   <= 2'b00;
      width_ff <= 2'b00;
      width_s  <= 2'b00;
    end else begin
      perst_ff <= {perst_ff[0], pcie_perst_n};
      lnk_ff   <= {lnk_ff[0], pcie.user_lnk_up};
      width_ff <= pcie.pl_sel_lnk_width;
      width_s  <= width_ff;
    end
  end

  // Next-state, timer and status counters.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q + TMR_W'(1);
    retry_d = retry_q;
    dtc_d   = dtc_q;
    werr_d  = werr_q;
    used_d  = used_q;
    chk_d   = 1'b0;
    tick_d  = tick_q + TICK_W'(1);

    // Width is re-checked one cycle after a completed directed change.
    if (chk_q && (width_s < EXP_W)) werr_d = 1'b1;

    if (!perst_s || sw_rst_core) begin
      state_d = ST_RESET;
      retry_d = 4'd0;
    end else begin
      case (state_q)
        ST_RESET: if (timer_q == TMR_W'(DEBOUNCE_CYC - 1)) state_d = ST_HOLD;
        ST_HOLD:  if (timer_q == TMR_W'(HOLD_CYC - 1))     state_d = ST_TRAIN;
        ST_TRAIN: begin
          if (lnk_s) begin
            state_d = ST_UP;
            used_d  = 1'b0;
          end else if (timer_q == TMR_W'(TRAIN_TO_CYC - 1)) begin
            retry_d = retry_q + 4'd1;
            state_d = (retry_d == 4'(MAX_RETRIES)) ? ST_FAIL : ST_HOLD;
          end
        end
        ST_UP, ST_RETRAIN: begin
          if (!lnk_s || pcie.pl_received_hot_rst) begin
            state_d = ST_TRAIN;
          end else if (state_q == ST_UP) begin
            if ((RETRAIN_EN != 0) && !used_q && (pcie.pl_ltssm_state == LTSSM_L0) &&
                (width_s < EXP_W)) begin
              state_d = ST_RETRAIN;
              used_d  = 1'b1;
              if (dtc_q != 8'hFF) dtc_d = dtc_q + 8'd1;
            end
          end else if (pcie.pl_directed_change_done) begin
            state_d = ST_UP;
            chk_d   = 1'b1;
          end else if (timer_q == TMR_W'(RETRAIN_TO_CYC - 1)) begin
            state_d = ST_UP;
            werr_d  = 1'b1;
          end
        end
        ST_FAIL: state_d = ST_FAIL;
        default: state_d = ST_RESET;
      endcase
    end

    // RESET also restarts debounce on every glitch, even without a state change.
    if ((state_d != state_q) || (state_d == ST_RESET && (!perst_s || sw_rst_core)))
      timer_d = '0;
  end

  // State and registered outputs, decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q                      <= ST_RESET;
      timer_q                      <= '0;
      retry_q                      <= 4'd0;
      dtc_q                        <= 8'd0;
      werr_q                       <= 1'b0;
      used_q                       <= 1'b0;
      chk_q                        <= 1'b0;
      tick_q                       <= '0;
      pcie.core_rst                <= 1'b1;
      pcie.subsys_rst              <= 1'b1;
      pcie.pl_directed_link_change <= 2'b00;
      led_state                    <= 1'b0;
    end else begin
      state_q                      <= state_d;
      timer_q                      <= timer_d;
      retry_q                      <= retry_d;
      dtc_q                        <= dtc_d;
      werr_q                       <= werr_d;
      used_q                       <= used_d;
      chk_q                        <= chk_d;
      tick_q                       <= tick_d;
      pcie.core_rst                <= (state_d == ST_RESET) || (state_d == ST_HOLD) ||
                                      (state_d == ST_FAIL);
      pcie.subsys_rst              <= !((state_d == ST_UP) || (state_d == ST_RETRAIN));
      pcie.pl_directed_link_change <= (state_d == ST_RETRAIN) ? 2'b01 : 2'b00;
      led_state                    <= (state_d == ST_UP)   ? 1'b1 :
                                      (state_d == ST_FAIL) ? tick_d[LED_BIT-3] :
                                                             tick_d[LED_BIT];
    end
  end

  assign pcie.pl_directed_link_width = EXP_W;
  assign pcie.pl_directed_link_auton = 1'b0;
  assign link_state                  = state_q;
  assign retry_count                 = retry_q;
  assign downtrain_count             = dtc_q;
  assign width_err                   = werr_q;

endmodule

// File: tb/tb_pcileech_pcie_link_supervisor.sv
// Self-checking bench for pcileech_pcie_link_supervisor: randomized scenarios checked
// against expectations derived from the supervisor's timing rules.
module tb_pcileech_pcie_link_supervisor;

  localparam int DEB     = 8;
  localparam int HOLD    = 4;
  localparam int TRN_TO  = 64;
  localparam int RTR_TO  = 32;
  localparam int MAXR    = 2;
  localparam int LEDB    = 4;
  localparam int EXPW    = 2;   // x4
  localparam int SYNC    = 2;   // two-flop synchroniser latency

  localparam logic [2:0] S_RESET = 3'd0, S_HOLD = 3'd1, S_TRAIN = 3'd2,
                         S_UP = 3'd3, S_RETRAIN = 3'd4, S_FAIL = 3'd5;

  logic       clk, rst_n, pcie_perst_n, sw_rst_core;
  logic [2:0] link_state;
  logic [3:0] retry_count;
  logic [7:0] downtrain_count;
  logic       width_err, led_state;
  int         cyc;
  int         n_chk, n_pass;

  pcileech_pcie_link_supervisor_if pcie_if ();

  pcileech_pcie_link_supervisor #(
    .LANES(4), .DEBOUNCE_CYC(DEB), .HOLD_CYC(HOLD), .TRAIN_TO_CYC(TRN_TO),
    .RETRAIN_TO_CYC(RTR_TO), .MAX_RETRIES(MAXR), .RETRAIN_EN(1), .LED_BIT(LEDB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pcie_perst_n(pcie_perst_n), .sw_rst_core(sw_rst_core),
    .pcie(pcie_if), .link_state(link_state), .retry_count(retry_count),
    .downtrain_count(downtrain_count), .width_err(width_err), .led_state(led_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running reference for the LED blink: clock edges since reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_state(input string tag, input logic [2:0] st, input int budget);
    int n = 0;
    while (link_state != st && n < budget) begin
      step(1);
      n++;
    end
    check(tag, 32'(link_state), 32'(st));
  endtask

  // Cycles spent in state st, starting at the current sample point.
  task automatic dwell(input logic [2:0] st, input int budget, output int n);
    n = 0;
    while (link_state == st && n < budget) begin
      step(1);
      n++;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_core_rst"}, 32'(pcie_if.core_rst), 32'd1);
    check({tag, "_subsys"},   32'(pcie_if.subsys_rst), 32'd1);
    check({tag, "_change"},   32'(pcie_if.pl_directed_link_change), 32'd0);
    check({tag, "_state"},    32'(link_state), 32'(S_RESET));
    check({tag, "_counts"},   {20'd0, retry_count, downtrain_count}, 32'd0);
    check({tag, "_werr_led"}, {30'd0, width_err, led_state}, 32'd0);
  endtask

  task automatic do_reset(input logic [1:0] w, input logic lnk);
    rst_n = 1'b0;
    pcie_perst_n = 1'b1;
    sw_rst_core = 1'b0;
    pcie_if.user_lnk_up = lnk;
    pcie_if.pl_sel_lnk_width = w;
    pcie_if.pl_ltssm_state = 6'h16;
    pcie_if.pl_received_hot_rst = 1'b0;
    pcie_if.pl_directed_change_done = 1'b0;
    step(3);
    check_reset_vals("rst");
    rst_n = 1'b1;
  endtask

  // Waits for TRAIN entry (core_rst release) and returns the edge index it happened on.
  task automatic wait_core_release(output int at);
    int n = 0;
    while (pcie_if.core_rst !== 1'b0 && n < 200) begin
      step(1);
      n++;
    end
    at = cyc;
  endtask

  initial begin
    int at, d, k, n;
    logic [1:0] w0, wf;
    n_chk = 0;
    n_pass = 0;

    // Bring-up: release at SYNC+DEB+HOLD edges, link-up seen after SYNC+1 edges.
    do_reset(2'd2, 1'b0);
    wait_core_release(at);
    check("t1_core_rel_cycle", 32'(at), 32'(SYNC + DEB + HOLD));
    check("t1_train", 32'(link_state), 32'(S_TRAIN));
    check("t1_subsys_train", 32'(pcie_if.subsys_rst), 32'd1);
    check("t1_led_slow", 32'(led_state), 32'(cyc[LEDB]));
    check("t1_dir_width", 32'(pcie_if.pl_directed_link_width), 32'(EXPW));
    check("t1_dir_auton", 32'(pcie_if.pl_directed_link_auton), 32'd0);
    d = $urandom_range(0, 20);
    step(d);
    pcie_if.user_lnk_up = 1'b1;
    dwell(S_TRAIN, 20, n);
    check("t1_lnk_latency", 32'(n), 32'(SYNC + 1));
    check("t1_up", 32'(link_state), 32'(S_UP));
    check("t1_up_rsts", {30'd0, pcie_if.core_rst, pcie_if.subsys_rst}, 32'd0);
    check("t1_led_up", 32'(led_state), 32'd1);
    step(10);
    check("t1_stays_up", 32'(link_state), 32'(S_UP));
    check("t1_no_dtc", 32'(downtrain_count), 32'd0);

    // PERST# one-cycle glitch restarts debounce from the glitch.
    for (int it = 0; it < 3; it++) begin
      do_reset(2'd2, 1'b0);
      k = $urandom_range(1, 10);
      step(k);
      pcie_perst_n = 1'b0;
      step(1);
      pcie_perst_n = 1'b1;
      wait_core_release(at);
      check("t2_glitch_rel_cycle", 32'(at), 32'(k + SYNC + 1 + DEB + HOLD));
    end

    // No link-up: timeout, retry via HOLD, then FAIL after MAX_RETRIES timeouts.
    do_reset(2'd2, 1'b0);
    wait_core_release(at);
    dwell(S_TRAIN, 200, n);
    check("t3_train_to_1", 32'(n), 32'(TRN_TO));
    check("t3_hold_again", 32'(link_state), 32'(S_HOLD));
    check("t3_retry1", 32'(retry_count), 32'd1);
    check("t3_core_rst_hold", 32'(pcie_if.core_rst), 32'd1);
    dwell(S_HOLD, 20, n);
    check("t3_hold_len", 32'(n), 32'(HOLD));
    dwell(S_TRAIN, 200, n);
    check("t3_train_to_2", 32'(n), 32'(TRN_TO));
    check("t3_fail", 32'(link_state), 32'(S_FAIL));
    check("t3_retry2", 32'(retry_count), 32'(MAXR));
    check("t3_fail_rsts", {30'd0, pcie_if.core_rst, pcie_if.subsys_rst}, 32'd3);
    for (int i = 0; i < 8; i++) begin
      check("t3_led_fast", 32'(led_state), 32'(cyc[LEDB-3]));
      step(1);
    end
    pcie_if.user_lnk_up = 1'b1;
    step(6);
    check("t3_fail_sticky", 32'(link_state), 32'(S_FAIL));
    pcie_perst_n = 1'b0;
    wait_state("t3_perst_exit", S_RESET, SYNC + 2);
    check("t3_retry_clr", 32'(retry_count), 32'd0);

    // Down-train retrain with random initial/final widths.
    for (int it = 0; it < 4; it++) begin
      w0 = 2'($urandom_range(0, 1));
      wf = 2'($urandom_range(0, 3));
      do_reset(w0, 1'b1);
      wait_state("t4_retrain", S_RETRAIN, 40);
      check("t4_change", 32'(pcie_if.pl_directed_link_change), 32'd1);
      check("t4_dtc", 32'(downtrain_count), 32'd1);
      check("t4_subsys_rt", 32'(pcie_if.subsys_rst), 32'd0);
      pcie_if.pl_sel_lnk_width = wf;
      step($urandom_range(SYNC + 1, 10));
      pcie_if.pl_directed_change_done = 1'b1;
      step(1);
      pcie_if.pl_directed_change_done = 1'b0;
      check("t4_back_up", 32'(link_state), 32'(S_UP));
      check("t4_change_clr", 32'(pcie_if.pl_directed_link_change), 32'd0);
      check("t4_werr_pre", 32'(width_err), 32'd0);
      step(1);
      check("t4_werr", 32'(width_err), 32'(int'(wf) < EXPW));
      step(5);
      check("t4_one_retrain", {link_state, downtrain_count}, {S_UP, 8'd1});
    end

    // Retrain timeout, no second retrain until a fresh TRAIN->UP, link loss / hot reset.
    do_reset(2'd1, 1'b1);
    wait_state("t5_retrain", S_RETRAIN, 40);
    dwell(S_RETRAIN, 100, n);
    check("t5_rt_timeout", 32'(n), 32'(RTR_TO));
    check("t5_up_werr", {link_state, width_err}, {S_UP, 1'b1});
    check("t5_change_clr", 32'(pcie_if.pl_directed_link_change), 32'd0);
    step(20);
    check("t5_no_rt2", {link_state, downtrain_count}, {S_UP, 8'd1});
    pcie_if.user_lnk_up = 1'b0;
    wait_state("t5_lnk_loss", S_TRAIN, SYNC + 2);
    check("t5_loss_subsys", 32'(pcie_if.subsys_rst), 32'd1);
    check("t5_loss_retry", 32'(retry_count), 32'd0);
    pcie_if.user_lnk_up = 1'b1;
    wait_state("t5_rt_again", S_RETRAIN, 10);
    check("t5_dtc2", 32'(downtrain_count), 32'd2);
    pcie_if.pl_received_hot_rst = 1'b1;
    step(1);
    pcie_if.pl_received_hot_rst = 1'b0;
    check("t5_hot_rst", {link_state, pcie_if.subsys_rst, pcie_if.pl_directed_link_change},
          {S_TRAIN, 1'b1, 2'b00});
    wait_state("t5_rt_third", S_RETRAIN, 10);
    check("t5_dtc3", 32'(downtrain_count), 32'd3);
    check("t5_werr_sticky", 32'(width_err), 32'd1);

    // Software reset clears retry count; async reset mid-TRAIN.
    do_reset(2'd2, 1'b0);
    wait_state("t6_train", S_TRAIN, 40);
    wait_state("t6_hold", S_HOLD, TRN_TO + 5);
    check("t6_retry1", 32'(retry_count), 32'd1);
    pcie_if.user_lnk_up = 1'b1;
    wait_state("t6_up", S_UP, 20);
    check("t6_retry_kept", 32'(retry_count), 32'd1);
    sw_rst_core = 1'b1;
    step(1);
    check("t6_sw_rst", {link_state, retry_count, pcie_if.core_rst, pcie_if.subsys_rst},
          {S_RESET, 4'd0, 1'b1, 1'b1});
    sw_rst_core = 1'b0;
    pcie_if.user_lnk_up = 1'b0;
    wait_state("t6_train2", S_TRAIN, 40);
    step(2);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("t6_async");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Global watchdog so the bench always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
